// File: rtl/shift_sched.sv
// Two-requester scheduler around one shared 16-bit SLL/SRA shifter; ROR is built from two passes.
// Optional feature macro: SHIFT_SCHED_ROR_EN (two-pass rotate-right on op 2'b10).
module shift_sched #(
    parameter int unsigned ARB_MODE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a_valid,
    output logic        req_a_ready,
    input  logic [1:0]  req_a_op,
    input  logic [15:0] req_a_data,
    input  logic [3:0]  req_a_shamt,
    input  logic        req_b_valid,
    output logic        req_b_ready,
    input  logic [1:0]  req_b_op,
    input  logic [15:0] req_b_data,
    input  logic [3:0]  req_b_shamt,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_src,
    output logic        res_err,
    output logic        busy
);
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 4;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;
`ifdef SHIFT_SCHED_ROR_EN
    localparam logic ROR_EN = 1'b1;
`else
    localparam logic ROR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t        state, state_d;
    logic          rr_ptr, rr_ptr_d;
    logic [1:0]    op_q, op_d;
    logic [DW-1:0] data_q, data_d;
    logic [SW-1:0] shamt_q, shamt_d;
    logic          src_q, src_d;
    logic [DW-1:0] res_data_d;
    logic          res_src_d, res_err_d;
    logic          grant_b, unsupported;
    logic          sh_mode;
    logic [SW-1:0] sh_amt;
    logic [DW-1:0] sh_out;
`ifdef SHIFT_SCHED_ROR_EN
    logic [DW-1:0] tmp_q, tmp_d;
`endif

    // The single shared shifter: mode 0 = SLL, mode 1 = SRA
    always_comb begin : shifter
        if (sh_mode) sh_out = DW'($signed(data_q) >>> sh_amt);
        else         sh_out = data_q << sh_amt;
    end

    assign grant_b = req_b_valid && (!req_a_valid || ((ARB_MODE != 0) && rr_ptr));
    assign unsupported = (op_q == OP_RSV) || ((op_q == OP_ROR) && !ROR_EN);

    always_comb begin : next_state
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        op_d        = op_q;
        data_d      = data_q;
        shamt_d     = shamt_q;
        src_d       = src_q;
        res_data_d  = res_data;
        res_src_d   = res_src;
        res_err_d   = res_err;
        req_a_ready = 1'b0;
        req_b_ready = 1'b0;
        sh_mode     = op_q[0];
        sh_amt      = shamt_q;
`ifdef SHIFT_SCHED_ROR_EN
        tmp_d       = tmp_q;
`endif
        case (state)
            IDLE: begin
                req_a_ready = req_a_valid && !grant_b;
                req_b_ready = grant_b;
                if (req_a_valid || req_b_valid) begin
                    op_d     = grant_b ? req_b_op    : req_a_op;
                    data_d   = grant_b ? req_b_data  : req_a_data;
                    shamt_d  = grant_b ? req_b_shamt : req_a_shamt;
                    src_d    = grant_b;
                    rr_ptr_d = !grant_b;
                    state_d  = PASS1;
                end
            end
            PASS1: begin
`ifdef SHIFT_SCHED_ROR_EN
                // Rotate: first pass builds the wrapped-around low bits
                if (op_q == OP_ROR) begin
                    sh_mode = 1'b0;
                    sh_amt  = SW'(4'd0 - shamt_q);
                    tmp_d   = sh_out;
                    state_d = PASS2;
                end else
`endif
                begin
                    res_src_d  = src_q;
                    res_err_d  = unsupported;
                    res_data_d = unsupported ? data_q : sh_out;
                    state_d    = DONE;
                end
            end
`ifdef SHIFT_SCHED_ROR_EN
            PASS2: begin
                // SRA then strip the sign fill so only the shifted-down bits remain
                sh_mode    = 1'b1;
                res_data_d = (sh_out & ({DW{1'b1}} >> shamt_q)) | tmp_q;
                res_src_d  = src_q;
                res_err_d  = 1'b0;
                state_d    = DONE;
            end
`endif
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            op_q      <= 2'b00;
            data_q    <= '0;
            shamt_q   <= '0;
            src_q     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_src   <= 1'b0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
`ifdef SHIFT_SCHED_ROR_EN
            tmp_q     <= '0;
`endif
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            op_q      <= op_d;
            data_q    <= data_d;
            shamt_q   <= shamt_d;
            src_q     <= src_d;
            res_valid <= (state_d == DONE);
            res_data  <= res_data_d;
            res_src   <= res_src_d;
            res_err   <= res_err_d;
            busy      <= (state_d != IDLE);
`ifdef SHIFT_SCHED_ROR_EN
            tmp_q     <= tmp_d;
`endif
        end
    end
endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: scoreboard of expected results, round-robin and fixed-priority instances.
module tb_shift_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, b_valid, b_ready;
    logic [1:0]  a_op, b_op;
    logic [15:0] a_data, b_data;
    logic [3:0]  a_shamt, b_shamt;
    logic        res_valid, res_ready, res_src, res_err, busy;
    logic [15:0] res_data;

    logic        z_a_valid, z_a_ready, z_b_valid, z_b_ready;
    logic        z_res_valid, z_res_ready, z_res_src, z_res_err, z_busy;
    logic [15:0] z_res_data;

    shift_sched #(.ARB_MODE(1)) dut (
        .clk(clk), .rst(rst),
        .req_a_valid(a_valid), .req_a_ready(a_ready), .req_a_op(a_op),
        .req_a_data(a_data), .req_a_shamt(a_shamt),
        .req_b_valid(b_valid), .req_b_ready(b_ready), .req_b_op(b_op),
        .req_b_data(b_data), .req_b_shamt(b_shamt),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_src(res_src), .res_err(res_err), .busy(busy)
    );

    shift_sched #(.ARB_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_a_valid(z_a_valid), .req_a_ready(z_a_ready), .req_a_op(2'b00),
        .req_a_data(16'h0001), .req_a_shamt(4'd1),
        .req_b_valid(z_b_valid), .req_b_ready(z_b_ready), .req_b_op(2'b00),
        .req_b_data(16'h0002), .req_b_shamt(4'd1),
        .res_valid(z_res_valid), .res_ready(z_res_ready), .res_data(z_res_data),
        .res_src(z_res_src), .res_err(z_res_err), .busy(z_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic        src;
        logic        err;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int passes = 0;
    int total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Reference: rotate via a doubled word, independent of the two-pass scheme
    function automatic exp_t model(input logic src, input logic [1:0] op,
                                   input logic [15:0] d, input logic [3:0] s);
        exp_t e;
        logic [31:0] dd;
        e.src = src; e.err = 1'b0; e.lat = 2; e.cyc = 0; e.data = d;
        case (op)
            2'b00: e.data = d << s;
            2'b01: e.data = 16'($signed(d) >>> s);
`ifdef SHIFT_SCHED_ROR_EN
            2'b10: begin
                dd = {d, d} >> s;
                e.data = dd[15:0];
                e.lat = 3;
            end
`endif
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic side, input logic [1:0] op,
                        input logic [15:0] d, input logic [3:0] s);
        int n;
        exp_t e;
        @(negedge clk);
        if (side) begin b_valid = 1'b1; b_op = op; b_data = d; b_shamt = s; end
        else      begin a_valid = 1'b1; a_op = op; a_data = d; a_shamt = s; end
        #1;
        n = 0;
        while (!(side ? b_ready : a_ready) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        e = model(side, op, d, s);
        e.cyc = cyc + e.lat;
        exp_q.push_back(e);
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic collect();
        int n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!res_valid && n < 20);
        chk("result_timeout", 32'(res_valid), 32'd1);
        chk("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("latency", 32'(cyc), 32'(e.cyc));
            chk("res_data", 32'(res_data), 32'(e.data));
            chk("res_src", 32'(res_src), 32'(e.src));
            chk("res_err", 32'(res_err), 32'(e.err));
        end
    endtask

    int g1[4];
    int g0[4];
    int ng1, ng0, zb;
    logic [15:0] held;

    initial begin
        a_valid = 0; b_valid = 0; a_op = 0; b_op = 0;
        a_data = 0; b_data = 0; a_shamt = 0; b_shamt = 0;
        res_ready = 1; z_a_valid = 0; z_b_valid = 0; z_res_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_src_err", 32'({res_src, res_err}), 32'd0);
        chk("rst_ready_idle", 32'({a_ready, b_ready}), 32'd0);

        // Basic shifts on both sides, including the shamt=15 edge
        send(1'b0, 2'b00, 16'h0001, 4'd15); collect();
        send(1'b1, 2'b01, 16'h8000, 4'd4);  collect();
        send(1'b1, 2'b01, 16'h7FF0, 4'd4);  collect();
        send(1'b0, 2'b00, 16'hBEEF, 4'd0);  collect();
        send(1'b1, 2'b11, 16'h5A5A, 4'd3);  collect();

        // Rotate cases (or error passthrough when rotate is not built)
        send(1'b0, 2'b10, 16'h1234, 4'd4);  collect();
        send(1'b0, 2'b10, 16'h8001, 4'd1);  collect();
        send(1'b0, 2'b10, 16'hABCD, 4'd0);  collect();
        send(1'b1, 2'b10, 16'h0F0F, 4'd15); collect();

        // Arbitration with both requesters always valid
        reset_all();
        @(negedge clk);
        a_op = 2'b00; a_data = 16'h0001; a_shamt = 4'd1;
        b_op = 2'b00; b_data = 16'h0002; b_shamt = 4'd1;
        a_valid = 1; b_valid = 1; z_a_valid = 1; z_b_valid = 1;
        ng1 = 0; ng0 = 0; zb = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (a_ready && ng1 < 4) begin g1[ng1] = 0; ng1++; end
            else if (b_ready && ng1 < 4) begin g1[ng1] = 1; ng1++; end
            if (z_a_ready && ng0 < 4) begin g0[ng0] = 0; ng0++; end
            else if (z_b_ready && ng0 < 4) begin g0[ng0] = 1; ng0++; end
            if (z_b_ready) zb++;
            @(negedge clk);
        end
        a_valid = 0; b_valid = 0; z_a_valid = 0; z_b_valid = 0;
        chk("rr_grant_count", 32'(ng1), 32'd4);
        for (int i = 0; i < ng1; i++) chk("rr_grant_order", 32'(g1[i]), 32'(i % 2));
        chk("fixed_grant_count", 32'(ng0), 32'd4);
        for (int i = 0; i < ng0; i++) chk("fixed_grant_order", 32'(g0[i]), 32'd0);
        chk("fixed_b_never_ready", 32'(zb), 32'd0);
        repeat (6) @(negedge clk);
        chk("drain_idle", 32'({busy, z_busy}), 32'd0);

        // Back-pressure: result must hold while res_ready is low
        res_ready = 0;
        send(1'b0, 2'b00, 16'h00FF, 4'd8); collect();
        held = res_data;
        a_valid = 1; b_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("hold_data", 32'(res_data), 32'(held));
            chk("hold_valid_busy", 32'({res_valid, busy}), 32'b11);
            chk("hold_no_ready", 32'({a_ready, b_ready}), 32'd0);
        end
        a_valid = 0; b_valid = 0;
        res_ready = 1;
        @(posedge clk); #1;
        chk("release_idle", 32'({res_valid, busy}), 32'd0);

        // Reset mid-rotate drops the op and restores A priority
        send(1'b0, 2'b10, 16'h1234, 4'd4);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_valid", 32'(res_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_err", 32'(res_err), 32'd0);
        a_valid = 1; b_valid = 1;
        #1;
        chk("post_rst_grant", 32'({a_ready, b_ready}), 32'b10);
        a_valid = 0; b_valid = 0;
        repeat (2) @(negedge clk);
        chk("no_stray_result", 32'(res_valid), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
